// File: rtl/adc_clk_axil_slave.sv
// AXI4-Lite slave with four RW registers driving a programmable divided ADC sample clock
// with an optional finite burst length.
module adc_clk_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              ADC_CLK,
  output logic                              BURST_DONE
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e        r_wstate;
  r_state_e        r_rstate;

  logic            r_awready;
  logic            r_wready;
  logic            r_bvalid;
  logic            r_aw_got;
  logic            r_w_got;
  logic [1:0]      r_aw_idx;
  logic [DW-1:0]   r_wdata;
  logic [NB-1:0]   r_wstrb;

  logic            r_arready;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata;

  logic [DW-1:0]   r_regs [4];

  logic [31:0]     r_cnt;
  logic [31:0]     r_edges;
  logic            r_adc_clk;
  logic            r_done;
  logic            r_en_q;

  logic            w_reg_wr;
  logic            w_en;
  logic [31:0]     w_div_eff;
  logic [31:0]     w_term;
  logic [31:0]     w_npulse;
  logic            w_burst_hit;
  logic            w_unused;

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign ADC_CLK       = r_adc_clk;
  assign BURST_DONE    = r_done;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Register update happens in the single cycle where both address and data are held.
  assign w_reg_wr = (r_wstate == WIdle) && r_aw_got && r_w_got;

  // Write channel: AW and W are accepted independently, then one response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= WIdle;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      unique case (r_wstate)
        WIdle: begin
          if (r_aw_got && r_w_got) begin
            r_wstate  <= WResp;
            r_bvalid  <= 1'b1;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
          end else begin
            if (r_awready && S_AXI_AWVALID) begin
              r_aw_idx  <= S_AXI_AWADDR[3:2];
              r_aw_got  <= 1'b1;
              r_awready <= 1'b0;
            end else if (!r_aw_got) begin
              r_awready <= 1'b1;
            end
            if (r_wready && S_AXI_WVALID) begin
              r_wdata  <= S_AXI_WDATA;
              r_wstrb  <= S_AXI_WSTRB;
              r_w_got  <= 1'b1;
              r_wready <= 1'b0;
            end else if (!r_w_got) begin
              r_wready <= 1'b1;
            end
          end
        end
        WResp: begin
          if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_wstate <= WIdle;
          end
        end
        default: r_wstate <= WIdle;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_wr) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (r_wstrb[b]) begin
          r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read channel: data captured on the address handshake, so a same-cycle write reads old.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rstate  <= RIdle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      unique case (r_rstate)
        RIdle: begin
          if (r_arready && S_AXI_ARVALID) begin
            r_rdata   <= r_regs[S_AXI_ARADDR[3:2]];
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= RData;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RData: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= RIdle;
          end
        end
        default: r_rstate <= RIdle;
      endcase
    end
  end

  assign w_en        = r_regs[0][0];
  assign w_div_eff   = (r_regs[1] == 32'd0) ? 32'd1 : r_regs[1];
  assign w_term      = w_div_eff - 32'd1;
  assign w_npulse    = r_regs[2];
  assign w_burst_hit = (w_npulse != 32'd0) && (r_edges >= w_npulse);

  // DIV and NPULSE are compared live so mid-run writes take effect on the next count.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cnt     <= '0;
      r_edges   <= '0;
      r_adc_clk <= 1'b0;
      r_done    <= 1'b0;
      r_en_q    <= 1'b0;
    end else begin
      r_en_q <= w_en;
      if (!w_en) begin
        r_cnt     <= '0;
        r_edges   <= '0;
        r_adc_clk <= 1'b0;
      end else begin
        if (!r_en_q) begin
          r_done <= 1'b0;
        end
        if (!r_done || !r_en_q) begin
          if (r_cnt >= w_term) begin
            r_cnt <= '0;
            if (w_burst_hit) begin
              r_adc_clk <= 1'b0;
              r_done    <= 1'b1;
            end else if (!r_adc_clk) begin
              r_adc_clk <= 1'b1;
              if (r_edges != 32'hFFFF_FFFF) begin
                r_edges <= r_edges + 32'd1;
              end
            end else begin
              r_adc_clk <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_clk_axil_slave.sv
// Directed bench for adc_clk_axil_slave: a closed-form model of the register file and
// divided clock is compared every cycle, plus literal checks of the key scenarios.
module tb_adc_clk_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        adc_clk;
  logic        burst_done;

  always #5 clk = ~clk;

  adc_clk_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ADC_CLK       (adc_clk),
    .BURST_DONE    (burst_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state
  logic [31:0] m_regs [4];
  longint      m_n;
  logic        m_done;
  logic        m_clk;
  longint      m_d;
  longint      m_ph;
  logic [3:0]  pend_addr;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;
  logic [3:0]  rd_addr;
  logic        prev_b;
  logic        prev_r;
  logic        prev_clk;
  int          cyc = 0;
  int          rises = 0;
  int          last_rise = 0;
  int          prev_rise = 0;
  logic        b_clk0;
  logic        b_clk1;

  // Clock model: after n enabled cycles, ADC_CLK = floor(n/D) mod 2 until 2*NPULSE
  // half-periods have elapsed, after which it is 0 and BURST_DONE is set.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_n = 0;
      m_done = 1'b0;
      prev_b = 1'b0;
      prev_r = 1'b0;
      prev_clk = 1'b0;
    end else begin
      m_d = (m_regs[1] == 32'd0) ? 64'sd1 : longint'(m_regs[1]);
      if (m_regs[0][0]) begin
        m_n = m_n + 1;
        m_ph = m_n / m_d;
        if (m_regs[2] != 32'd0 && m_ph >= 2 * longint'(m_regs[2])) begin
          m_clk = 1'b0;
          m_done = 1'b1;
        end else begin
          m_clk = m_ph[0];
          m_done = 1'b0;
        end
      end else begin
        m_n = 0;
        m_clk = 1'b0;
      end
      chk("adc_clk", 32'(adc_clk), 32'(m_clk));
      chk("burst_done", 32'(burst_done), 32'(m_done));
      if (adc_clk && !prev_clk) begin
        rises = rises + 1;
        prev_rise = last_rise;
        last_rise = cyc;
      end
      if (rvalid && !prev_r) begin
        chk("rdata_model", rdata, m_regs[rd_addr[3:2]]);
        chk("rresp", 32'(rresp), 32'd0);
      end
      if (bvalid && !prev_b) begin
        chk("bresp", 32'(bresp), 32'd0);
        for (int b = 0; b < 4; b++) begin
          if (pend_strb[b]) m_regs[pend_addr[3:2]][8*b +: 8] = pend_data[8*b +: 8];
        end
      end
      prev_b = bvalid;
      prev_r = rvalid;
      prev_clk = adc_clk;
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bit aw_fire;
    bit w_fire;
    int t = 0;
    pend_addr = addr;
    pend_data = data;
    pend_strb = strb;
    @(posedge clk) #1;
    while (!(aw_done && w_done) && t < 50) begin
      if (!aw_done && t == aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && t == w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      @(posedge clk) #1;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire) begin wvalid = 1'b0; w_done = 1'b1; end
      t = t + 1;
    end
    chk("aw_w_accepted", 32'({aw_done, w_done}), 32'd3);
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 50) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("bvalid_seen", 32'(bvalid), 32'd1);
    b_clk0 = adc_clk;
    for (int i = 0; i <= b_dly; i++) begin
      @(negedge clk);
      chk("bvalid_held", 32'(bvalid), 32'd1);
      if (i == 0) b_clk1 = adc_clk;
    end
    @(posedge clk) #1 bready = 1'b1;
    @(negedge clk);
    @(posedge clk) #1 bready = 1'b0;
    @(negedge clk);
    chk("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int t = 0;
    rd_addr = addr;
    @(posedge clk) #1;
    arvalid = 1'b1;
    araddr = addr;
    @(negedge clk);
    while (!arready && t < 50) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("arready_seen", 32'(arready), 32'd1);
    @(posedge clk) #1 arvalid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!rvalid && t < 50) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("rvalid_seen", 32'(rvalid), 32'd1);
    data = rdata;
    @(negedge clk);
    chk("rvalid_held", 32'(rvalid), 32'd1);
    @(posedge clk) #1 rready = 1'b1;
    @(negedge clk);
    @(posedge clk) #1 rready = 1'b0;
  endtask

  task automatic read_chk(input logic [3:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    axi_read(addr, d);
    chk(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int t;
    // Reset held 200 ns: every output low
    #203;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_adc_clk", 32'(adc_clk), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    @(posedge clk) #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) read_chk(4'(i * 4), 32'd0, "rst_readback");

    // Basic RW; CTRL last so the clock starts with DIV/NPULSE already in place
    axi_write(4'hC, 32'd4, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd2, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    read_chk(4'h0, 32'd1, "rw_ctrl");
    read_chk(4'h4, 32'd2, "rw_div");
    read_chk(4'h8, 32'd3, "rw_npulse");
    read_chk(4'hC, 32'd4, "rw_scratch");

    // Byte strobe, AW-before-W and W-before-AW, BREADY held low 5 cycles
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b0010, 0, 2, 5);
    read_chk(4'hC, 32'h0000_FF04, "strb_aw_first");
    axi_write(4'hD, 32'hFFFF_FFFF, 4'b0010, 3, 0, 0);
    read_chk(4'hC, 32'h0000_FF04, "strb_w_first");

    // Free-running DIV=3: period 6
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd3, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
    base = rises;
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    idle(30);
    chk("free_run_rises_ge2", 32'(rises - base >= 2), 32'd1);
    chk("free_run_period", 32'(last_rise - prev_rise), 32'd6);
    // EN cleared mid-high phase drops the clock the next cycle
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd6, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    t = 0;
    while (!adc_clk && t < 40) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("stop_saw_rise", 32'(adc_clk), 32'd1);
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    chk("stop_high_at_land", 32'(b_clk0), 32'd1);
    chk("stop_low_next", 32'(b_clk1), 32'd0);

    // Burst DIV=2, NPULSE=4
    axi_write(4'h4, 32'd2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd4, 4'hF, 0, 0, 0);
    base = rises;
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    idle(40);
    chk("burst_rises", 32'(rises - base), 32'd4);
    chk("burst_clk_low", 32'(adc_clk), 32'd0);
    chk("burst_done_set", 32'(burst_done), 32'd1);
    axi_write(4'h0, 32'd0, 4'hF, 0, 0, 0);
    chk("burst_done_held_en0", 32'(burst_done), 32'd1);
    base = rises;
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    chk("burst_done_rearm", 32'(burst_done), 32'd0);
    idle(40);
    chk("burst2_rises", 32'(rises - base), 32'd4);
    chk("burst2_done", 32'(burst_done), 32'd1);

    // Reset with AW accepted and W still pending
    @(posedge clk) #1;
    awvalid = 1'b1;
    awaddr = 4'h4;
    t = 0;
    @(negedge clk);
    while (!awready && t < 20) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("pend_aw_ready", 32'(awready), 32'd1);
    @(posedge clk) #1 awvalid = 1'b0;
    idle(3);
    chk("pend_no_bvalid", 32'(bvalid), 32'd0);
    read_chk(4'h4, 32'd2, "pend_div_unchanged");
    @(posedge clk) #3 rst_n = 1'b0;
    #20;
    chk("midrst_bvalid", 32'(bvalid), 32'd0);
    chk("midrst_awready", 32'(awready), 32'd0);
    chk("midrst_adc_clk", 32'(adc_clk), 32'd0);
    @(posedge clk) #1 rst_n = 1'b1;
    idle(3);
    chk("postrst_bvalid", 32'(bvalid), 32'd0);
    chk("postrst_awready", 32'(awready), 32'd1);
    chk("postrst_wready", 32'(wready), 32'd1);
    read_chk(4'h4, 32'd0, "postrst_div");
    axi_write(4'hC, 32'h0000_0055, 4'hF, 0, 0, 0);
    read_chk(4'hC, 32'h0000_0055, "postrst_write");

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
